// File: rtl/mips_mem_pkg.sv
// Shared data-memory definitions for the MEM-stage store buffer: legal word
// range, buffered entry layout and the range check applied to incoming stores.
package mips_mem_pkg;

    localparam int unsigned DMEM_LO = 1000;
    localparam int unsigned DMEM_HI = 3999;   // exclusive upper bound
    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    function automatic logic in_dmem_range(input logic [31:0] addr);
        return (addr >= 32'(DMEM_LO)) && (addr < 32'(DMEM_HI));
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store storage with read/write pointers and occupancy count.
// STORE_BUFFER_FWD_EN exposes the raw slots so the top can search them.
module store_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [AW-1:0]                 i_addr,
    input  logic [DW-1:0]                 i_data,
    input  logic                          i_pop,
    output logic [AW-1:0]                 o_head_addr,
    output logic [DW-1:0]                 o_head_data,
    output logic                          o_full,
    output logic                          o_empty
`ifdef STORE_BUFFER_FWD_EN
   ,output logic [DEPTH-1:0][AW-1:0]      o_addr,
    output logic [DEPTH-1:0][DW-1:0]      o_data,
    output logic [$clog2(DEPTH)-1:0]      o_rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [PW-1:0]            r_wr;
    logic [PW-1:0]            r_rd;
    logic [CW-1:0]            r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !rst) begin
            r_addr[r_wr] <= i_addr;
            r_data[r_wr] <= i_data;
        end
    end

    assign o_head_addr = r_addr[r_rd];
    assign o_head_data = r_data[r_rd];
    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);

`ifdef STORE_BUFFER_FWD_EN
    assign o_addr   = r_addr;
    assign o_data   = r_data;
    assign o_rd_ptr = r_rd;
    assign o_count  = r_count;
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM stage and data memory: arbitrates the single
// memory port between loads and in-order drains. STORE_BUFFER_FWD_EN adds forwarding.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_stall,
    output logic          empty,
    output logic          addr_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writeData,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_readData
);

    import mips_mem_pkg::*;

    logic          w_full;
    logic          w_empty;
    logic          w_in_range;
    logic          w_accept;
    logic          w_push;
    logic          w_ld_port;
    logic          w_drain;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic          r_addr_err;

    assign st_ready   = !w_full;
    assign w_accept   = st_valid && st_ready && !rst;
    assign w_in_range = in_dmem_range(32'(st_addr));
    assign w_push     = w_accept && w_in_range;

`ifdef STORE_BUFFER_FWD_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] w_slot_addr;
    logic [DEPTH-1:0][DW-1:0] w_slot_data;
    logic [PW-1:0]            w_rd_ptr;
    logic [CW-1:0]            w_count;
    logic [PW-1:0]            w_slot;
    logic                     w_hit;
    logic [DW-1:0]            w_fwd_data;

    store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_addr      (st_addr),
        .i_data      (st_data),
        .i_pop       (w_drain),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_addr      (w_slot_addr),
        .o_data      (w_slot_data),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (w_count)
    );

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = w_rd_ptr + PW'(i);
            if (ld_req && (CW'(i) < w_count) && (w_slot_addr[w_slot] == ld_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = w_slot_data[w_slot];
            end
        end
    end

    assign w_ld_port = ld_req && !w_hit && !w_full;
    assign ld_stall  = ld_req && !w_hit && w_full;
`else
    store_buffer_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_addr      (st_addr),
        .i_data      (st_data),
        .i_pop       (w_drain),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Without forwarding a load can never bypass a pending store.
    assign w_ld_port = ld_req && w_empty;
    assign ld_stall  = ld_req && !w_empty;
`endif

    // Reset blocks the drain so no half-issued write escapes during reset.
    assign w_drain = !w_empty && !w_ld_port && !rst;

    always_comb begin
        mem_address   = '0;
        mem_writeData = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        ld_data       = '0;
        if (w_ld_port) begin
            mem_address = ld_addr;
            mem_read    = 1'b1;
            ld_data     = mem_readData;
        end else if (w_drain) begin
            mem_address   = w_head_addr;
            mem_writeData = w_head_data;
            mem_write     = 1'b1;
        end
`ifdef STORE_BUFFER_FWD_EN
        if (w_hit) ld_data = w_fwd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_addr_err <= 1'b0;
        else     r_addr_err <= w_accept && !w_in_range;
    end

    assign addr_err = r_addr_err;
    assign empty    = w_empty;

endmodule
